// File: rtl/sram_loop_reader_pkg.sv
// Shared types and constants for the SRAM loop-nest reader.
package sram_loop_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  localparam int unsigned FIFO_DEPTH = 3;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small shift-register FIFO; entry 0 is always the head, so the head is a plain register.
module stream_fifo
  import sram_loop_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o,
  output logic                         not_empty_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (pop_i && (count_q != '0)) begin
      for (int k = 0; k < int'(DEPTH) - 1; k++) begin
        mem_d[k] = mem_q[k+1];
      end
      count_d = count_q - CW'(1);
    end
    // Push lands after the shift so push+pop at any count keeps order.
    if (push_i && (count_d < CW'(DEPTH))) begin
      mem_d[count_d] = data_i;
      count_d        = count_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        mem_q[k] <= '0;
      end
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_o      = mem_q[0];
  assign not_empty_o = (count_q != '0);

endmodule

// File: rtl/sram_loop_reader.sv
// Walks a 2-D loop nest issuing SRAM reads with II spacing and credit flow control,
// and streams the returned words out through a 3-entry FIFO.
module sram_loop_reader
  import sram_loop_reader_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned OUTER_N      = 2,
  parameter int unsigned INNER_N      = 4,
  parameter int unsigned II           = 1,
  parameter int unsigned BASE         = 0,
  parameter int unsigned OUTER_STRIDE = 4,
  parameter int unsigned INNER_STRIDE = 1,
  localparam int unsigned AW          = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    sram_addr,
  output logic             sram_ren,
  input  logic [WIDTH-1:0] sram_q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam logic [AW-1:0] BaseAddr  = AW'(BASE);
  localparam logic [AW-1:0] OuterStep = AW'(OUTER_STRIDE);
  localparam logic [AW-1:0] InnerStep = AW'(INNER_STRIDE);
  localparam int unsigned   CW        = $clog2(FIFO_DEPTH + 1);

  state_e        state_q;
  logic [31:0]   i_q, j_q, ii_cnt_q;
  logic [AW-1:0] addr_q, row_base_q;
  logic          inflight_q, inflight_last_q;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic [WIDTH:0] fifo_head;
  logic          fifo_not_empty;
  logic          last_iter;
  logic          pop;

  assign last_iter   = (i_q == OUTER_N - 1) && (j_q == INNER_N - 1);
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};

  // Reads in flight plus buffered words never exceed the FIFO depth.
  assign sram_ren  = (state_q == StIssue) && (ii_cnt_q == '0) &&
                     (credit_used < (CW+1)'(FIFO_DEPTH));
  assign sram_addr = addr_q;

  assign out_valid = fifo_not_empty;
  assign out_data  = fifo_head[WIDTH-1:0];
  assign out_last  = fifo_not_empty & fifo_head[WIDTH];
  assign pop       = out_valid & out_ready;
  assign done      = pop & out_last;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      i_q             <= '0;
      j_q             <= '0;
      ii_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      addr_q          <= BaseAddr;
      row_base_q      <= BaseAddr;
    end else begin
      inflight_q      <= sram_ren;
      inflight_last_q <= sram_ren & last_iter;

      if (sram_ren) begin
        ii_cnt_q <= II - 1;
      end else if (ii_cnt_q != '0) begin
        ii_cnt_q <= ii_cnt_q - 32'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StIssue;
            i_q        <= '0;
            j_q        <= '0;
            ii_cnt_q   <= '0;
            addr_q     <= BaseAddr;
            row_base_q <= BaseAddr;
          end
        end
        StIssue: begin
          if (sram_ren) begin
            if (last_iter) begin
              state_q <= StDrain;
            end else if (j_q == INNER_N - 1) begin
              // Row wrap: next address is the following row's start.
              j_q        <= '0;
              i_q        <= i_q + 32'd1;
              row_base_q <= row_base_q + OuterStep;
              addr_q     <= row_base_q + OuterStep;
            end else begin
              j_q    <= j_q + 32'd1;
              addr_q <= addr_q + InnerStep;
            end
          end
        end
        StDrain: begin
          if (done) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .data_i      ({inflight_last_q, sram_q}),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head),
    .not_empty_o (fifo_not_empty)
  );

endmodule

// File: tb/tb_sram_loop_reader.sv
// Bench for sram_loop_reader: three configurations (default, II=3, address wrap) checked
// against a loop-nest model every cycle, plus fixed-timing expectations.
module tb_sram_loop_reader;

  localparam int NI = 3;
  localparam int unsigned C_ON   [NI] = '{2, 2, 2};
  localparam int unsigned C_IN   [NI] = '{4, 4, 2};
  localparam int unsigned C_II   [NI] = '{1, 3, 1};
  localparam int unsigned C_BASE [NI] = '{0, 0, 28};
  localparam int unsigned C_OS   [NI] = '{4, 4, 8};
  localparam int unsigned C_IS   [NI] = '{1, 1, 1};

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic busy [NI];
  logic done [NI];
  logic ren [NI];
  logic valid [NI];
  logic olast [NI];
  logic [4:0]  addr [NI];
  logic [31:0] q [NI];
  logic [31:0] dout [NI];

  int cyc = 0;
  int t0 = 0;
  int phase = 0;
  int timeouts = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM contents: word k holds 100+k, one-cycle read latency.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (ren[g]) q[g] <= 32'd100 + 32'(addr[g]);
    end
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_loop_reader #(
      .WIDTH        (32),
      .DEPTH        (32),
      .OUTER_N      (C_ON[g]),
      .INNER_N      (C_IN[g]),
      .II           (C_II[g]),
      .BASE         (C_BASE[g]),
      .OUTER_STRIDE (C_OS[g]),
      .INNER_STRIDE (C_IS[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy[g]),
      .done      (done[g]),
      .sram_addr (addr[g]),
      .sram_ren  (ren[g]),
      .sram_q    (q[g]),
      .out_data  (dout[g]),
      .out_valid (valid[g]),
      .out_ready (out_ready),
      .out_last  (olast[g])
    );
  end

  // Address of the n-th element in loop order, straight from the loop-nest formula.
  function automatic logic [4:0] exp_addr(input int g, input int unsigned n);
    int unsigned i, j;
    i = n / C_IN[g];
    j = n % C_IN[g];
    return 5'(C_BASE[g] + i * C_OS[g] + j * C_IS[g]);
  endfunction

  task automatic chk(input string name, input int g, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, want %0d", name, g, cyc, act, exp);
    end
  endtask

  bit          busy_m [NI];
  int unsigned rd_n [NI];
  int unsigned out_n [NI];
  int unsigned outst [NI];
  int          last_ren [NI];
  bit          stall_p [NI];
  logic [31:0] prev_d [NI];
  int          seen_to = 0;
  logic [4:0]  wrap_lit [4] = '{5'd28, 5'd29, 5'd4, 5'd5};

  always @(negedge clk) begin
    int rel;
    int unsigned n_el;
    bit hs;
    rel = cyc - t0;
    for (int g = 0; g < NI; g++) begin
      n_el = C_ON[g] * C_IN[g];
      if (!rst) begin
        chk("rst_busy", g, busy[g], 0);
        chk("rst_valid", g, valid[g], 0);
        chk("rst_ren", g, ren[g], 0);
        chk("rst_done", g, done[g], 0);
        chk("rst_last", g, olast[g], 0);
        chk("rst_addr", g, addr[g], C_BASE[g] % 32);
        busy_m[g] = 0; rd_n[g] = 0; out_n[g] = 0; outst[g] = 0;
        stall_p[g] = 0; last_ren[g] = -1000;
      end else begin
        chk("busy", g, busy[g], busy_m[g]);
        if (ren[g]) begin
          chk("ren_in_run", g, busy_m[g] && (rd_n[g] < n_el), 1);
          chk("addr", g, addr[g], exp_addr(g, rd_n[g]));
          chk("credit", g, outst[g] < 3, 1);
          chk("ii_gap", g, (cyc - last_ren[g]) >= int'(C_II[g]), 1);
          rd_n[g]++;
          outst[g]++;
          last_ren[g] = cyc;
        end
        if (stall_p[g]) begin
          chk("hold_valid", g, valid[g], 1);
          chk("hold_data", g, dout[g], prev_d[g]);
        end
        hs = valid[g] && out_ready;
        if (valid[g]) begin
          chk("extra_elem", g, out_n[g] < n_el, 1);
          chk("data", g, dout[g], 100 + exp_addr(g, out_n[g]));
          chk("last", g, olast[g], out_n[g] == n_el - 1);
        end
        chk("done", g, done[g], hs && (out_n[g] == n_el - 1));
        if (hs) begin
          out_n[g]++;
          outst[g]--;
        end
        stall_p[g] = valid[g] && !out_ready;
        prev_d[g]  = dout[g];
        if (done[g]) begin
          chk("done_all_read", g, rd_n[g], n_el);
          busy_m[g] = 0;
        end else if (start && !busy_m[g]) begin
          busy_m[g] = 1; rd_n[g] = 0; out_n[g] = 0; outst[g] = 0; last_ren[g] = -1000;
        end
      end
    end

    if (rst && phase == 1 && rel >= 1 && rel <= 24) begin
      chk("lit_ren0", 0, ren[0], rel <= 8);
      if (ren[0]) chk("lit_addr0", 0, addr[0], rel - 1);
      chk("lit_valid0", 0, valid[0], rel >= 3 && rel <= 10);
      if (valid[0]) chk("lit_data0", 0, dout[0], 100 + rel - 3);
      chk("lit_done0", 0, done[0], rel == 10);
      chk("lit_busy0", 0, busy[0], rel <= 10);
      chk("lit_ren1", 1, ren[1], (rel % 3 == 1) && rel <= 22);
      chk("lit_valid1", 1, valid[1], (rel % 3 == 0) && rel >= 3);
      if (valid[1]) chk("lit_data1", 1, dout[1], 100 + rel / 3 - 1);
      chk("lit_done1", 1, done[1], rel == 24);
      chk("lit_ren2", 2, ren[2], rel <= 4);
      if (ren[2] && rel <= 4) chk("lit_addr2", 2, addr[2], wrap_lit[rel-1]);
    end
    if (rst && phase == 2 && rel >= 3 && rel <= 12) begin
      chk("bp_valid", 0, valid[0], 1);
      chk("bp_data", 0, dout[0], 100);
      if (rel == 12) chk("bp_reads", 0, rd_n[0], 3);
    end
    if (timeouts != seen_to) begin
      chk("timeout", 0, timeouts, seen_to);
      seen_to = timeouts;
    end
  end

  task automatic pulse_start(input int ph);
    start = 1'b1;
    t0    = cyc;
    phase = ph;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while ((busy[0] || busy[1] || busy[2]) && n < 600);
    if (n >= 600) timeouts++;
    repeat (2) @(posedge clk);
    #1 phase = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Nominal run with fixed timing expectations.
    pulse_start(1);
    wait_idle();

    // Backpressure: ready low on cycles 2..12.
    start = 1'b1; t0 = cyc; phase = 2;
    while (cyc - t0 < 13) begin
      @(posedge clk);
      #1 start = 1'b0;
      out_ready = !((cyc - t0) >= 2 && (cyc - t0) <= 12);
    end
    wait_idle();

    // Second start at cycle 4 must be ignored; timing identical to nominal.
    pulse_start(1);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Reset at cycle 5 for two cycles, then a fresh run replays everything.
    pulse_start(0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    pulse_start(1);
    wait_idle();

    // Random backpressure and random start pulses.
    for (int k = 0; k < 1500; k++) begin
      out_ready = ($urandom_range(3) != 0);
      start     = ($urandom_range(15) == 0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
